// File: rtl/row_scan_pkg.sv
// Shared types and constants for the row scan controller and its timer.
package row_scan_pkg;

  localparam int NUM_ROWS = 8;
  localparam int SEL_W    = 3;

  // Index of the final row of a sweep; reaching its end decides stop vs wrap.
  localparam logic [SEL_W-1:0] LAST_ROW = SEL_W'(NUM_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } scan_state_e;

  // Width needed to hold either a dwell or a blank count in one shared timer.
  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Down-counter shared by the dwell and blank phases. Loading N gives N+1
// cycles before tc is seen, so callers load (length - 1).
module scan_timer
  import row_scan_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Load has priority; decrement saturates at zero so tc stays asserted.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/row_scan_ctrl.sv
// Row scan controller: steps a 3-to-8 decoder through eight rows with a
// programmable dwell per row and an enable-off blank gap between rows.
// sel/en connect straight to the decoder select and enable pins.
module row_scan_ctrl
  import row_scan_pkg::*;
#(
  parameter int DWELL_W = 8,
  parameter int BLANK_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [BLANK_W-1:0] blank,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy,
  output logic               row_strobe,
  output logic               done
);

  localparam int TW = max_w(DWELL_W, BLANK_W);

  scan_state_e        state, state_n;
  logic [SEL_W-1:0]   sel_n, sel_inc;
  logic               en_n, busy_n, strobe_n, done_n;

  // Settings captured at start; live inputs are ignored while a sweep runs.
  logic               mode_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [BLANK_W-1:0] blank_q;
  logic               cfg_load;

  logic               tmr_load, tmr_dec, tmr_tc;
  logic [TW-1:0]      tmr_val;
  logic [TW-1:0]      dwell_m1_in, dwell_m1_q, blank_m1_q;

  // dwell=0 behaves as a one-cycle dwell, so both 0 and 1 load zero.
  assign dwell_m1_in = (dwell   == '0) ? '0 : TW'(dwell)   - TW'(1);
  assign dwell_m1_q  = (dwell_q == '0) ? '0 : TW'(dwell_q) - TW'(1);
  // Only used when blank_q is non-zero, so no underflow case.
  assign blank_m1_q  = TW'(blank_q) - TW'(1);

  scan_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Next-state and next-output decode; every output is then registered.
  always_comb begin
    state_n  = state;
    sel_n    = sel;
    en_n     = 1'b0;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    cfg_load = 1'b0;
    sel_inc  = sel + SEL_W'(1);   // wraps 7 -> 0 for continuous mode

    case (state)
      IDLE: begin
        sel_n = '0;
        // stop outranks start
        if (start && !stop) begin
          cfg_load = 1'b1;
          state_n  = ACTIVE;
          en_n     = 1'b1;
          strobe_n = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = dwell_m1_in;
        end
      end

      ACTIVE: begin
        if (stop) begin
          state_n = IDLE;
          sel_n   = '0;
        end else if (!tmr_tc) begin
          en_n    = 1'b1;
          tmr_dec = 1'b1;
        end else if ((sel == LAST_ROW) && !mode_q) begin
          // single sweep finished: no trailing blank after the last row
          state_n = IDLE;
          sel_n   = '0;
          done_n  = 1'b1;
        end else if (blank_q != '0) begin
          // blank keeps the previous row index on sel
          state_n  = BLANK;
          tmr_load = 1'b1;
          tmr_val  = blank_m1_q;
        end else begin
          sel_n    = sel_inc;
          en_n     = 1'b1;
          strobe_n = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = dwell_m1_q;
        end
      end

      BLANK: begin
        if (stop) begin
          state_n = IDLE;
          sel_n   = '0;
        end else if (!tmr_tc) begin
          tmr_dec = 1'b1;
        end else begin
          state_n  = ACTIVE;
          sel_n    = sel_inc;
          en_n     = 1'b1;
          strobe_n = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = dwell_m1_q;
        end
      end

      default: begin
        state_n = IDLE;
        sel_n   = '0;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      row_strobe <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      en         <= en_n;
      busy       <= busy_n;
      row_strobe <= strobe_n;
      done       <= done_n;
    end
  end

  // Sweep settings, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= 1'b0;
      dwell_q <= '0;
      blank_q <= '0;
    end else if (cfg_load) begin
      mode_q  <= mode;
      dwell_q <= dwell;
      blank_q <= blank;
    end
  end

endmodule
